adc_clock: RTL and testbench

//  Clock and capture front end for the MCA pulse-height path. Drives the

---
 rtl/adc_clock.sv | 132 +++++++++++++
 tb/tb_adc_clock.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/adc_clock.sv
// ADC sample-clock divider and comparator-gated peak capture for the MCA front end.
// Optional pile-up counter during the dead window is enabled by defining ADC_CLOCK_PILEUP_EN.
module adc_clock #(
  parameter int DATA_W    = 10,
  parameter int ADC_DIV   = 2,
  parameter int MIN_WIDTH = 2,
  parameter int DEAD_TIME = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              comparator,
  input  logic [DATA_W-1:0] adc_in,
  output logic              adc_clk,
  output logic [DATA_W-1:0] peak,
  output logic              peak_valid,
  output logic              reject,
  output logic              busy
`ifdef ADC_CLOCK_PILEUP_EN
  ,
  output logic [15:0]       pileup_cnt
`endif
);

  localparam int CNT_W = (ADC_DIV > 2) ? $clog2(ADC_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(ADC_DIV - 1);
  localparam logic [CNT_W-1:0] DIV_HALF = CNT_W'(ADC_DIV / 2);
  localparam logic [15:0] MIN_W     = 16'(MIN_WIDTH);
  localparam logic [15:0] DEAD_LAST = 16'(DEAD_TIME - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TRACK = 2'd1;
  localparam logic [1:0] DEAD  = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              sample_en;
  logic              sync1, sync2, sync3;
  logic              rise, fall;
  logic [DATA_W-1:0] acc, acc_nx;
  logic [15:0]       width, width_nx;
  logic [15:0]       dead_cnt;

  // adc_clk is registered from the current count, so it rises on the edge that ends the cnt==0 cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      adc_clk <= 1'b0;
    end else begin
      cnt     <= (cnt == DIV_LAST) ? '0 : cnt + 1'b1;
      adc_clk <= (cnt < DIV_HALF);
    end
  end

  assign sample_en = (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= comparator;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;
  assign fall = ~sync2 & sync3;
  assign busy = (state != IDLE);

  // A sample landing in the fall cycle is folded in before the width/peak decision.
  always_comb begin
    acc_nx   = acc;
    width_nx = width;
    if (sample_en) begin
      width_nx = (width == '1) ? width : width + 16'd1;
      if (adc_in > acc) acc_nx = adc_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      width      <= '0;
      dead_cnt   <= '0;
      peak       <= '0;
      peak_valid <= 1'b0;
      reject     <= 1'b0;
    end else begin
      peak_valid <= 1'b0;
      reject     <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= TRACK;
            acc   <= '0;
            width <= '0;
          end
        end
        TRACK: begin
          acc   <= acc_nx;
          width <= width_nx;
          if (fall) begin
            if (width_nx >= MIN_W) begin
              peak       <= acc_nx;
              peak_valid <= 1'b1;
            end else begin
              reject <= 1'b1;
            end
            dead_cnt <= '0;
            state    <= (DEAD_TIME == 0) ? IDLE : DEAD;
          end
        end
        DEAD: begin
          if (dead_cnt == DEAD_LAST) state <= IDLE;
          else dead_cnt <= dead_cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADC_CLOCK_PILEUP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pileup_cnt <= '0;
    else if ((state == DEAD) && rise && (pileup_cnt != '1)) pileup_cnt <= pileup_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_adc_clock.sv
// Directed self-checking bench for adc_clock: default instance plus a DEAD_TIME=8 instance.
module tb_adc_clock;

  logic       clk = 1'b0;
  logic       rst;
  logic       comparator;
  logic [9:0] adc_in;

  logic       adc_clk, peak_valid, reject, busy;
  logic [9:0] peak;
  logic       adc_clk_d, peak_valid_d, reject_d, busy_d;
  logic [9:0] peak_d;
`ifdef ADC_CLOCK_PILEUP_EN
  logic [15:0] pileup, pileup_d;
`endif

  int checks = 0;
  int failures = 0;
  int pv_cnt = 0, rj_cnt = 0, pvd_cnt = 0, rjd_cnt = 0, both_cnt = 0;
  int pv0, rj0, pvd0, rjd0;

  adc_clock dut (
    .clk(clk), .rst(rst), .comparator(comparator), .adc_in(adc_in),
    .adc_clk(adc_clk), .peak(peak), .peak_valid(peak_valid), .reject(reject), .busy(busy)
`ifdef ADC_CLOCK_PILEUP_EN
    , .pileup_cnt(pileup)
`endif
  );

  adc_clock #(.DEAD_TIME(8)) dut_d (
    .clk(clk), .rst(rst), .comparator(comparator), .adc_in(adc_in),
    .adc_clk(adc_clk_d), .peak(peak_d), .peak_valid(peak_valid_d), .reject(reject_d), .busy(busy_d)
`ifdef ADC_CLOCK_PILEUP_EN
    , .pileup_cnt(pileup_d)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (peak_valid) pv_cnt++;
    if (reject) rj_cnt++;
    if (peak_valid_d) pvd_cnt++;
    if (reject_d) rjd_cnt++;
    if ((peak_valid && reject) || (peak_valid_d && reject_d)) both_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; comparator = 1'b0; adc_in = '0;
    tick(3);
    chk("rst_adc_clk", 32'(adc_clk), 0);
    chk("rst_peak", 32'(peak), 0);
    chk("rst_peak_valid", 32'(peak_valid), 0);
    chk("rst_reject", 32'(reject), 0);
    chk("rst_busy", 32'(busy), 0);
`ifdef ADC_CLOCK_PILEUP_EN
    chk("rst_pileup", 32'(pileup), 0);
`endif
    rst = 1'b0;
    tick(1); chk("adc_clk_1", 32'(adc_clk), 1);
    tick(1); chk("adc_clk_2", 32'(adc_clk), 0);
    tick(1); chk("adc_clk_3", 32'(adc_clk), 1);
    tick(1); chk("adc_clk_4", 32'(adc_clk), 0);

    // single event, adc_in=1, with exact strobe latency
    adc_in = 10'd1; comparator = 1'b1;
    tick(3); chk("busy_track", 32'(busy), 1);
    tick(2); comparator = 1'b0;
    tick(2); chk("pv_not_early", 32'(peak_valid), 0);
    tick(1);
    chk("pv_strobe", 32'(peak_valid), 1);
    chk("peak_1", 32'(peak), 1);
    chk("no_reject_1", 32'(reject), 0);
    chk("busy_idle", 32'(busy), 0);
    tick(1); chk("pv_one_cycle", 32'(peak_valid), 0);

    // second event, adc_in=2
    adc_in = 10'd2; comparator = 1'b1;
    tick(5); comparator = 1'b0;
    tick(4);
    chk("peak_2", 32'(peak), 2);
    chk("pv_count_2", 32'(pv_cnt), 2);
    chk("rj_count_0", 32'(rj_cnt), 0);

    // ramp 3,9,5
    comparator = 1'b1; adc_in = 10'd3;
    tick(4); adc_in = 10'd9;
    tick(2); adc_in = 10'd5;
    tick(4); comparator = 1'b0;
    tick(4);
    chk("peak_ramp", 32'(peak), 9);
    chk("pv_count_3", 32'(pv_cnt), 3);

    // ramp 7,7
    comparator = 1'b1; adc_in = 10'd7;
    tick(4); adc_in = 10'd7;
    tick(4); comparator = 1'b0;
    tick(4);
    chk("peak_equal", 32'(peak), 7);
    chk("pv_count_4", 32'(pv_cnt), 4);

    // single-sample pulse is rejected
    adc_in = 10'd15; comparator = 1'b1;
    tick(2); comparator = 1'b0;
    tick(2); chk("rj_not_early", 32'(reject), 0);
    tick(1);
    chk("reject_strobe", 32'(reject), 1);
    chk("reject_no_pv", 32'(peak_valid), 0);
    chk("peak_kept", 32'(peak), 7);
    tick(1);
    chk("reject_one_cycle", 32'(reject), 0);
    chk("rj_count_1", 32'(rj_cnt), 1);
    chk("pv_count_still_4", 32'(pv_cnt), 4);

    // dead window on the DEAD_TIME=8 instance
    rst = 1'b1; tick(1); rst = 1'b0; tick(2);
    pvd0 = pvd_cnt; rjd0 = rjd_cnt;
    adc_in = 10'd4; comparator = 1'b1;
    tick(5); comparator = 1'b0;
    tick(3);
    chk("dead_pv", 32'(peak_valid_d), 1);
    chk("dead_peak_4", 32'(peak_d), 4);
    chk("dead_busy", 32'(busy_d), 1);
    adc_in = 10'd6; comparator = 1'b1;
    tick(5); comparator = 1'b0;
    tick(10);
    chk("dead_pv_count", 32'(pvd_cnt - pvd0), 1);
    chk("dead_rj_count", 32'(rjd_cnt - rjd0), 0);
    chk("dead_peak_held", 32'(peak_d), 4);
    chk("dead_exit_idle", 32'(busy_d), 0);
    chk("nodead_peak_6", 32'(peak), 6);
`ifdef ADC_CLOCK_PILEUP_EN
    chk("pileup_d", 32'(pileup_d), 1);
    chk("pileup_nodead", 32'(pileup), 0);
`endif

    // reset in the middle of an event aborts with no strobe
    pv0 = pv_cnt; rj0 = rj_cnt;
    adc_in = 10'd5; comparator = 1'b1;
    tick(4); chk("abort_busy_pre", 32'(busy), 1);
    rst = 1'b1; #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_adc_clk", 32'(adc_clk), 0);
    chk("abort_peak", 32'(peak), 0);
    comparator = 1'b0;
    tick(1); rst = 1'b0;
    tick(6);
    chk("abort_no_pv", 32'(pv_cnt - pv0), 0);
    chk("abort_no_rj", 32'(rj_cnt - rj0), 0);
    chk("abort_peak_after", 32'(peak), 0);
    chk("strobes_exclusive", 32'(both_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
